cpu_clkctl: RTL and testbench

Parametrised successor to the ad-hoc CPU clock divider and power-on reset hold logic in the top level. It runs entirely in the clki domain and produces a one-cycle clock-enable pulse, cpu_ce, for the CPU. Three CPU clock modes are provided:
- free-run at a runtime-selectable rate
- single-step from a debounced button
- halt

A reset sequencer holds the CPU in reset for a programmable number of CPU ticks after power-on or a soft reset request. A retired-tick counter is exported for debug display.

---
 rtl/cpu_clkctl.sv | 140 ++++++++++++++
 tb/tb_cpu_clkctl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clkctl.sv
// CPU clock-enable generator: power-of-two divider, run/step/halt modes,
// power-on/soft reset sequencer and a retired-tick counter for debug display.
module cpu_clkctl #(
    parameter int SEL_W     = 5,
    parameter int RST_TICKS = 3,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clki,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic             sw_rst,
    output logic             cpu_ce,
    output logic             cpu_rst,
    output logic [CNT_W-1:0] tick_cnt,
    output logic [1:0]       state
);

    localparam int DIV_W = 1 << SEL_W;
    localparam int DB_W  = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        S_RESET_SEQ = 2'b00,
        S_RUN       = 2'b01,
        S_STEP      = 2'b10,
        S_HALT      = 2'b11
    } state_t;

    state_t             state_q, state_d, mode_state;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d, div_term;
    logic [SEL_W-1:0]   div_sel_q, div_sel_d;
    logic               div_tick, sel_changed;
    logic               sync1_q, sync1_d, sync2_q, sync2_d;
    logic               stable_q, stable_d, step_req;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [7:0]         rst_cnt_q, rst_cnt_d;
    logic               cpu_ce_q, cpu_ce_d, cpu_rst_q, cpu_rst_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;

    always_comb begin
        // Divider: a rate change restarts the period so the new rate is exact.
        div_sel_d   = div_sel;
        div_term    = ({{(DIV_W-1){1'b0}}, 1'b1} << div_sel_q) - {{(DIV_W-1){1'b0}}, 1'b1};
        sel_changed = (div_sel != div_sel_q);
        div_tick    = !sel_changed && (div_cnt_q == div_term);
        div_cnt_d   = (sel_changed || div_tick) ? '0 : div_cnt_q + 1'b1;

        // Button synchroniser and debounce; step_req fires on the accepted rising edge.
        sync1_d  = step_btn;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        step_req = stable_d && !stable_q;

        case (mode)
            2'b00:   mode_state = S_RUN;
            2'b01:   mode_state = S_STEP;
            default: mode_state = S_HALT;
        endcase

        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        tick_cnt_d = tick_cnt_q;
        cpu_ce_d   = 1'b0;
        if (sw_rst) begin
            state_d    = S_RESET_SEQ;
            rst_cnt_d  = '0;
            tick_cnt_d = '0;
        end else begin
            case (state_q)
                S_RESET_SEQ: begin
                    if (rst_cnt_q == 8'(RST_TICKS)) begin
                        state_d = mode_state;
                    end else if (div_tick) begin
                        cpu_ce_d  = 1'b1;
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    cpu_ce_d = div_tick;
                    state_d  = mode_state;
                end
                S_STEP: begin
                    cpu_ce_d = step_req;
                    state_d  = mode_state;
                end
                default: begin
                    state_d = mode_state;
                end
            endcase
            if (cpu_ce_d && state_q != S_RESET_SEQ) begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
        cpu_rst_d = (state_d == S_RESET_SEQ);
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET_SEQ;
            div_cnt_q  <= '0;
            div_sel_q  <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            stable_q   <= 1'b0;
            db_cnt_q   <= '0;
            rst_cnt_q  <= '0;
            cpu_ce_q   <= 1'b0;
            cpu_rst_q  <= 1'b1;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            div_sel_q  <= div_sel_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            db_cnt_q   <= db_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            cpu_ce_q   <= cpu_ce_d;
            cpu_rst_q  <= cpu_rst_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign cpu_ce   = cpu_ce_q;
    assign cpu_rst  = cpu_rst_q;
    assign tick_cnt = tick_cnt_q;
    assign state    = state_q;

endmodule

// File: tb/tb_cpu_clkctl.sv
// Directed bench for cpu_clkctl: reset sequence, divider rate change, step
// debounce, halt, soft reset and tick counter wrap (second instance, CNT_W=4).
module tb_cpu_clkctl;

  logic        clki;
  logic        rst_n;
  logic [4:0]  div_sel;
  logic [1:0]  mode;
  logic        step_btn;
  logic        sw_rst;
  logic        cpu_ce, cpu_rst;
  logic [15:0] tick_cnt;
  logic [1:0]  state;
  logic        ce4, rst4;
  logic [3:0]  tick4;
  logic [1:0]  state4;

  int checks = 0;
  int errors = 0;

  cpu_clkctl dut (
    .clki(clki), .rst_n(rst_n), .div_sel(div_sel), .mode(mode),
    .step_btn(step_btn), .sw_rst(sw_rst), .cpu_ce(cpu_ce),
    .cpu_rst(cpu_rst), .tick_cnt(tick_cnt), .state(state)
  );

  cpu_clkctl #(.CNT_W(4)) dut4 (
    .clki(clki), .rst_n(rst_n), .div_sel(div_sel), .mode(mode),
    .step_btn(step_btn), .sw_rst(sw_rst), .cpu_ce(ce4),
    .cpu_rst(rst4), .tick_cnt(tick4), .state(state4)
  );

  // clock / reset
  initial begin
    clki = 1'b0;
    forever #5 clki = ~clki;
  end

  // driver tasks
  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  task automatic wait_ce(input int max_cyc, output int waited, output bit ok);
    ok = 1'b0;
    waited = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (cpu_ce) begin
        waited = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; div_sel = 5'd2; mode = 2'b00; step_btn = 1'b0; sw_rst = 1'b0;
    repeat (3) tick();
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %0b expected 1", cpu_rst); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_cpu_ce: got %0b expected 0", cpu_ce); end
    checks++; if (tick_cnt !== 16'd0) begin errors++; $display("FAIL reset_tick_cnt: got %0h expected 0", tick_cnt); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0b expected 00", state); end
  endtask

  task automatic test_reset_seq();
    int n = 0;
    int last = 0;
    int fall = -1;
    int p3 = -1;
    logic prev_rst = 1'b1;
    rst_n = 1'b1;
    for (int c = 1; c <= 60 && n < 6; c++) begin
      tick();
      if (prev_rst && !cpu_rst && fall < 0) fall = c;
      prev_rst = cpu_rst;
      if (cpu_ce) begin
        n++;
        if (n == 3) p3 = c;
        checks++;
        if (cpu_rst !== (n <= 3)) begin errors++; $display("FAIL seq_rst_pulse%0d: got %0b expected %0b", n, cpu_rst, (n <= 3)); end
        checks++;
        if (tick_cnt !== ((n <= 3) ? 16'd0 : 16'(n - 3))) begin
          errors++; $display("FAIL seq_tick_cnt%0d: got %0d expected %0d", n, tick_cnt, (n <= 3) ? 0 : n - 3);
        end
        if (n > 1) begin
          checks++;
          if (c - last != 4) begin errors++; $display("FAIL seq_spacing%0d: got %0d expected 4", n, c - last); end
        end
        last = c;
      end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL seq_pulse_count: got %0d expected 6", n); end
    checks++; if (fall != p3 + 1) begin errors++; $display("FAIL seq_rst_fall: got cycle %0d expected %0d", fall, p3 + 1); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL seq_state_run: got %0b expected 01", state); end
  endtask

  task automatic test_div_change();
    int waited;
    bit ok;
    logic [15:0] t0;
    logic exp_ce;
    div_sel = 5'd3;
    wait_ce(20, waited, ok);
    wait_ce(20, waited, ok);
    checks++; if (!ok || waited != 8) begin errors++; $display("FAIL div3_spacing: got %0d expected 8 (ok=%0b)", waited, ok); end
    t0 = tick_cnt;
    repeat (3) tick();
    div_sel = 5'd1;
    for (int off = 1; off <= 8; off++) begin
      tick();
      exp_ce = (off == 3 || off == 5 || off == 7);
      checks++;
      if (cpu_ce !== exp_ce) begin errors++; $display("FAIL div_change_off%0d: got %0b expected %0b", off, cpu_ce, exp_ce); end
    end
    checks++; if (tick_cnt !== t0 + 16'd3) begin errors++; $display("FAIL div_change_cnt: got %0d expected %0d", tick_cnt, t0 + 16'd3); end
  endtask

  task automatic test_step();
    logic [15:0] t0;
    int pulses = 0;
    mode = 2'b01;
    repeat (3) tick();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL step_state: got %0b expected 10", state); end
    t0 = tick_cnt;
    step_btn = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); if (cpu_ce) pulses++; end
    step_btn = 1'b0;
    for (int i = 0; i < 30; i++) begin tick(); if (cpu_ce) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL step_glitch: got %0d pulses expected 0", pulses); end
    step_btn = 1'b1;
    for (int i = 0; i < 40; i++) begin tick(); if (cpu_ce) pulses++; end
    step_btn = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); if (cpu_ce) pulses++; end
    checks++; if (pulses != 1) begin errors++; $display("FAIL step_press: got %0d pulses expected 1", pulses); end
    checks++; if (tick_cnt !== t0 + 16'd1) begin errors++; $display("FAIL step_cnt: got %0d expected %0d", tick_cnt, t0 + 16'd1); end
  endtask

  task automatic test_halt();
    logic [15:0] t0;
    int pulses = 0;
    int waited;
    bit ok;
    mode = 2'b10;
    repeat (2) tick();
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL halt_state: got %0b expected 11", state); end
    t0 = tick_cnt;
    for (int i = 0; i < 100; i++) begin tick(); if (cpu_ce) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL halt_pulses: got %0d expected 0", pulses); end
    checks++; if (tick_cnt !== t0) begin errors++; $display("FAIL halt_cnt: got %0d expected %0d", tick_cnt, t0); end
    mode = 2'b00;
    wait_ce(10, waited, ok);
    checks++; if (!ok) begin errors++; $display("FAIL halt_resume: got no pulse expected pulse within 10"); end
    tick();
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL resume_gap: got %0b expected 0", cpu_ce); end
    tick();
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL resume_cadence: got %0b expected 1", cpu_ce); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL resume_state: got %0b expected 01", state); end
  endtask

  task automatic test_sw_rst_wrap();
    bit found = 1'b0;
    int rst_pulses = 0;
    int post = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cpu_ce && tick_cnt == 16'h0010) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL swrst_reach16: got %0h expected pulse with 0010", tick_cnt); end
    tick();
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL swrst_ce: got %0b expected 0", cpu_ce); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL swrst_rst: got %0b expected 1", cpu_rst); end
    checks++; if (tick_cnt !== 16'd0) begin errors++; $display("FAIL swrst_cnt: got %0h expected 0", tick_cnt); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL swrst_state: got %0b expected 00", state); end
    for (int i = 0; i < 200 && post < 18; i++) begin
      tick();
      if (cpu_ce) begin
        if (cpu_rst) begin
          rst_pulses++;
          checks++; if (tick_cnt !== 16'd0) begin errors++; $display("FAIL swrst_seq_cnt: got %0d expected 0", tick_cnt); end
        end else begin
          post++;
          checks++; if (tick_cnt !== 16'(post)) begin errors++; $display("FAIL wrap_cnt16_%0d: got %0d expected %0d", post, tick_cnt, post); end
          checks++; if (tick4 !== 4'(post % 16)) begin errors++; $display("FAIL wrap_cnt4_%0d: got %0d expected %0d", post, tick4, post % 16); end
        end
      end
    end
    checks++; if (rst_pulses != 3) begin errors++; $display("FAIL swrst_rst_pulses: got %0d expected 3", rst_pulses); end
    checks++; if (post != 18) begin errors++; $display("FAIL wrap_post_pulses: got %0d expected 18", post); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL swrst_return_state: got %0b expected 01", state); end
    // async reset lands while cpu_ce is high, with no clock edge in between
    rst_n = 1'b0;
    #1;
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL async_ce: got %0b expected 0", cpu_ce); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL async_rst: got %0b expected 1", cpu_rst); end
    checks++; if (tick_cnt !== 16'd0) begin errors++; $display("FAIL async_cnt: got %0h expected 0", tick_cnt); end
    checks++; if (rst4 !== 1'b1 || tick4 !== 4'd0) begin errors++; $display("FAIL async_dut4: got rst %0b cnt %0d expected 1 0", rst4, tick4); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL async_state: got %0b expected 00", state); end
  endtask

  initial begin
    test_reset();
    test_reset_seq();
    test_div_change();
    test_step();
    test_halt();
    test_sw_rst_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
